// File: rtl/axi_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_add_pkg
//  Purpose  : Shared definitions for the summing-accumulator self-test path:
//             controller state encoding, 7-segment digit patterns (common with
//             the accumulator's encoder) and the running-sum width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_add_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    CHECK    = 2'd3
  } state_t;

  // Segment order a..g maps to bit6..bit0; index is the digit value.
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_DASH      = 7'b0000001;
  localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

  // Wide enough for num_count operands of all-ones without overflow.
  function automatic int sum_width(input int width, input int num_count);
    return width + $clog2(num_count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_add_source_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_add_source_if
//  Purpose  : Operand stream (valid/ready) plus 7-segment result return path
//             between the self-test source and the accumulator.
//  Ports    : m_valid/m_ready/m_data  operand stream, source -> accumulator
//             res_valid/res_ready     result handshake, accumulator -> source
//             res_ones/res_tens       segment patterns a..g (bit6..bit0)
//  Modports : master (self-test source), slave (accumulator side)
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_add_source_if #(
  parameter int WIDTH = 4
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             res_valid;
  logic             res_ready;
  logic [6:0]       res_ones;
  logic [6:0]       res_tens;

  modport master (
    output m_valid, m_data, res_ready,
    input  m_ready, res_valid, res_ones, res_tens
  );

  modport slave (
    input  m_valid, m_data, res_ready,
    output m_ready, res_valid, res_ones, res_tens
  );
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational 7-segment pattern to digit decoder. Any pattern
//             that is not exactly one of the ten digit glyphs (dash included)
//             decodes to 4'hF.
//  Ports    : pattern in  7  segments a..g (bit6..bit0)
//             digit   out 4  0..9, or 4'hF when illegal
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import axi_add_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit
);

  always_comb begin
    digit = DIGIT_ILLEGAL;
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_DIGIT[i]) digit = 4'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_add_source.sv
`default_nettype none
// ============================================================================
//  Module   : axi_add_source
//  Purpose  : Self-test driver for the summing accumulator. On start sends
//             NUM_COUNT operands (BASE, BASE+STEP, ... mod 2**WIDTH) while
//             keeping a local sum, then accepts the accumulator's two-digit
//             7-segment result and reports whether it matches.
//  Ports    : clk      in   clock, rising edge
//             reset    in   asynchronous, active-low reset
//             start    in   frame request, sampled only when idle
//             bus      if   master modport: operand stream + result return
//             busy     out  high whenever not idle
//             done     out  one-cycle pulse when a check completes
//             match    out  check result, valid with done, held until next
//             exp_sum  out  local sum of the last frame
//             timeout  out  result wait expired (held with match)
//  Macro    : ADD_SRC_TIMEOUT_EN - enables the TIMEOUT_CYC result-wait limit;
//             without it the result wait is unbounded and timeout stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_add_source
  import axi_add_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int NUM_COUNT   = 8,
  parameter int BASE        = 1,
  parameter int STEP        = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  axi_add_source_if.master                        bus,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    match,
  output logic [sum_width(WIDTH, NUM_COUNT)-1:0]  exp_sum,
  output logic                                    timeout
);

  localparam int SUM_W = sum_width(WIDTH, NUM_COUNT);
  localparam int CNT_W = $clog2(NUM_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_COUNT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data;
  logic [SUM_W-1:0] sum;
  logic [3:0]       ones_dec, tens_dec, ones_q, tens_q;
  logic [3:0]       ones_exp, tens_exp;
  logic             match_q, timeout_q, match_calc;
  logic             send_hs, last_hs, res_hs, wait_expired;

  seg7_decode u_ones (.pattern(bus.res_ones), .digit(ones_dec));
  seg7_decode u_tens (.pattern(bus.res_tens), .digit(tens_dec));

  assign send_hs = (state == SEND) && bus.m_ready;
  assign last_hs = send_hs && (count == LAST);
  assign res_hs  = (state == WAIT_RES) && bus.res_valid;

`ifdef ADD_SRC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;

  // Counts cycles spent in WAIT_RES; restarts on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wait_cnt <= '0;
    else if (state != WAIT_RES) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  // A result handshake in the same cycle takes priority over expiry.
  assign wait_expired = (state == WAIT_RES) && !bus.res_valid &&
                        (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.m_valid   = 1'b0;
    bus.res_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = SEND;
      end
      SEND: begin
        bus.m_valid = 1'b1;
        if (last_hs) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        bus.res_ready = 1'b1;
        if (res_hs || wait_expired) state_next = CHECK;
      end
      CHECK: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data      <= '0;
      count     <= '0;
      sum       <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        data      <= WIDTH'(BASE);
        count     <= '0;
        sum       <= '0;
        timeout_q <= 1'b0;
      end
      // Operand advances on every accepted beat, wrapping naturally at WIDTH.
      if (send_hs) begin
        sum   <= sum + SUM_W'(data);
        count <= count + 1'b1;
        data  <= data + WIDTH'(STEP);
      end
      if (res_hs) begin
        ones_q <= ones_dec;
        tens_q <= tens_dec;
      end else if (wait_expired) begin
        timeout_q <= 1'b1;
      end
      if (state == CHECK) match_q <= match_calc;
    end
  end

  assign ones_exp = 4'(sum % 10);
  assign tens_exp = 4'((sum % 100) / 10);

  // Digits captured on a previous frame are stale after a timeout, so the
  // timeout flag must veto the comparison.
  assign match_calc = !timeout_q &&
                      (ones_q != DIGIT_ILLEGAL) && (tens_q != DIGIT_ILLEGAL) &&
                      (ones_q == ones_exp) && (tens_q == tens_exp);

  assign match      = done ? match_calc : match_q;
  assign bus.m_data = data;
  assign exp_sum    = sum;
  // Without the timeout feature timeout_q can never be set and reduces to 0.
  assign timeout    = timeout_q;

endmodule
`default_nettype wire
